// File: rtl/ring_buffer_pkg.sv
// Shared defaults and reader state encoding for the ring-buffer readout path.
// No logic, so no latency or backpressure of its own.
package ring_buffer_pkg;

  localparam int RB_DEPTH = 8;
  localparam int RB_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } rd_state_t;

endpackage

// File: rtl/rb_checksum_acc.sv
// Running mod-2^WIDTH sum of accepted words; the result is visible one cycle after add_en.
// No backpressure: clear takes priority over add_en.
module rb_checksum_acc
  import ring_buffer_pkg::*;
#(
  parameter int WIDTH = RB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [WIDTH-1:0] add_dat,
  output logic [WIDTH-1:0] sum
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_dat;
    end
  end

endmodule

// File: rtl/ring_buffer_reader.sv
// Sweeps all DEPTH buffer entries out on a valid/ready port, then emits their checksum.
// Each word takes 2 cycles: address, then present. While out_ready is low, the word and readPtr hold.
module ring_buffer_reader
  import ring_buffer_pkg::*;
#(
  parameter int DEPTH = RB_DEPTH,
  parameter int WIDTH = RB_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [$clog2(DEPTH)-1:0] readPtr,
  input  logic [WIDTH-1:0]         dout,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic [WIDTH-1:0]         checksum,
  output logic                     cksum_valid,
  output logic                     start_err
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(DEPTH - 1);

  rd_state_t        state, state_nxt;
  logic [PTR_W-1:0] idx;
  logic [WIDTH-1:0] acc_sum;
  logic             out_hs;
  logic             at_last;
  logic             acc_clr;
  logic             acc_add;

  assign out_hs  = (state == ST_PRESENT) && out_valid && out_ready;
  assign at_last = (idx == LAST_IDX);
  assign acc_clr = (state == ST_IDLE) && start;
  // The last word is folded straight into checksum, so the accumulator skips it.
  assign acc_add = out_hs && !at_last;

  rb_checksum_acc #(.WIDTH(WIDTH)) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (acc_clr),
    .add_en  (acc_add),
    .add_dat (out_data),
    .sum     (acc_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_WAIT;
      ST_WAIT:    state_nxt = ST_PRESENT;
      ST_PRESENT: if (out_hs) state_nxt = at_last ? ST_DONE : ST_WAIT;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    cksum_valid = (state == ST_DONE);
    out_last    = out_valid && at_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readPtr   <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      checksum  <= '0;
      start_err <= 1'b0;
    end else begin
      start_err <= start && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            readPtr <= '0;
            idx     <= '0;
          end
        end
        // readPtr was updated on the previous edge, so dout now holds its word.
        ST_WAIT: begin
          out_data  <= dout;
          out_valid <= 1'b1;
        end
        ST_PRESENT: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            if (at_last) begin
              checksum <= acc_sum + out_data;
            end else begin
              idx     <= idx + 1'b1;
              readPtr <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          readPtr <= '0;
          idx     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_buffer_reader.sv
// Directed bench for ring_buffer_reader: behavioural buffer memory, hand-computed checksums.
module tb_ring_buffer_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  readPtr;
  logic [15:0] dout;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [15:0] checksum;
  logic        cksum_valid;
  logic        start_err;

  logic [15:0] mem [8];
  int          errors = 0;
  int          checks = 0;

  // Buffer read data settles within the cycle after readPtr moves.
  assign dout = mem[readPtr];

  always #5 clk = ~clk;

  ring_buffer_reader #(.DEPTH(8), .WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .readPtr     (readPtr),
    .dout        (dout),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .checksum    (checksum),
    .cksum_valid (cksum_valid),
    .start_err   (start_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [15:0] exp_sum, input int stall_word, input int stall_n,
                           input int err_word, input bit start_in_done);
    int cyc;
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int w = 0; w < 8; w++) begin
      n = 0;
      while (!out_valid && n < 4) begin
        step();
        cyc++;
        n++;
      end
      chk("word_valid", 32'(out_valid), 32'd1);
      if (w == stall_word) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          step();
          cyc++;
          chk("stall_data", 32'(out_data), 32'(mem[w]));
          chk("stall_ptr", 32'(readPtr), 32'(w));
          chk("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
      end
      chk("word_data", 32'(out_data), 32'(mem[w]));
      chk("word_ptr", 32'(readPtr), 32'(w));
      chk("word_last", 32'(out_last), 32'(w == 7));
      start = (w == err_word);
      step();
      cyc++;
      start = 1'b0;
      chk("start_err", 32'(start_err), 32'(w == err_word));
      chk("valid_drop", 32'(out_valid), 32'd0);
    end
    chk("cksum_valid_hi", 32'(cksum_valid), 32'd1);
    chk("checksum", 32'(checksum), 32'(exp_sum));
    chk("frame_cycles", 32'(cyc), 32'(17 + stall_n));
    start = start_in_done;
    step();
    start = 1'b0;
    chk("cksum_valid_lo", 32'(cksum_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ptr", 32'(readPtr), 32'd0);
    chk("checksum_hold", 32'(checksum), 32'(exp_sum));
    chk("done_start_err", 32'(start_err), 32'(start_in_done));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i + 1);
    step();
    chk("rst_ptr", 32'(readPtr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_cksum_valid", 32'(cksum_valid), 32'd0);
    chk("rst_start_err", 32'(start_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    // Words 1..8 sum to 36.
    run_frame(16'h0024, -1, 0, -1, 1'b0);
    run_frame(16'h0024, 3, 3, -1, 1'b0);
    run_frame(16'h0024, -1, 0, 2, 1'b0);

    // 8 * 0xFFFF = 0x7FFF8, which wraps to 0xFFF8.
    for (int i = 0; i < 8; i++) mem[i] = 16'hFFFF;
    run_frame(16'hFFF8, -1, 0, -1, 1'b1);

    // Abandon a frame by asserting reset while word 5 is presented.
    for (int i = 0; i < 8; i++) mem[i] = 16'(i + 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_ptr", 32'(readPtr), 32'd5);
    chk("pre_rst_data", 32'(out_data), 32'h6);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ptr", 32'(readPtr), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_checksum", 32'(checksum), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    step();
    chk("mid_rst_no_cksum", 32'(cksum_valid), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_no_cksum", 32'(cksum_valid), 32'd0);
    run_frame(16'h0024, -1, 0, -1, 1'b0);

    // Back-to-back frames: the second frame's checksum is 0x10 * 36 = 0x240.
    run_frame(16'h0024, -1, 0, -1, 1'b0);
    for (int i = 0; i < 8; i++) mem[i] = 16'((i + 1) * 16);
    run_frame(16'h0240, -1, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
